// File: rtl/mem_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_stage_pkg                                                        |
// | Shared funct3 codes, FSM state encoding and access-legality helper   |
// | for the memory-access stage.                                         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mem_stage_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  // Encoding-level illegality, independent of address alignment.
  function automatic logic f3_illegal(input logic ld, input logic st, input logic [2:0] f3);
    logic bad;
    bad = 1'b0;
    if (ld && st) begin
      bad = 1'b1;
    end else if (ld) begin
      bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    end else if (st) begin
      bad = (f3 >= 3'b011);
    end
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_stage_if                                                         |
// | Single-outstanding data-memory request/acknowledge bus.              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [29:0] addr;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  // Pipeline stage side: issues requests.
  modport master (
    output req, we, addr, wmask, wdata,
    input  rdata, ack
  );

  // Memory side: services requests.
  modport slave (
    input  req, we, addr, wmask, wdata,
    output rdata, ack
  );
endinterface
`default_nettype wire

// File: rtl/mem_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_align                                                            |
// | Byte-lane steering for stores, lane select + extension for loads,    |
// | and natural-alignment check.                                         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_align
  import mem_stage_pkg::*;
(
  input  wire logic [2:0]  funct3,
  input  wire logic [1:0]  addr,
  input  wire logic [31:0] rs2,
  input  wire logic [31:0] rdata,
  output logic      [3:0]  wmask,
  output logic      [31:0] wdata,
  output logic      [31:0] load_val,
  output logic             misalign
);

  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Move the addressed lane down to bit 0 for loads.
  always_comb begin
    w_shift = rdata >> {addr, 3'b000};
    w_byte  = w_shift[7:0];
    w_half  = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  // Store lane enables and replicated data.
  always_comb begin
    wmask = 4'b0000;
    wdata = 32'h0;
    case (funct3)
      F3_SB: begin
        wmask = 4'b0001 << addr;
        wdata = {4{rs2[7:0]}};
      end
      F3_SH: begin
        wmask = 4'b0011 << addr;
        wdata = {2{rs2[15:0]}};
      end
      F3_SW: begin
        wmask = 4'b1111;
        wdata = rs2;
      end
      default: ;
    endcase
  end

  // Load result with sign or zero extension.
  always_comb begin
    load_val = 32'h0;
    case (funct3)
      F3_LB:   load_val = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  load_val = {24'h0, w_byte};
      F3_LH:   load_val = {{16{w_half[15]}}, w_half};
      F3_LHU:  load_val = {16'h0, w_half};
      F3_LW:   load_val = rdata;
      default: ;
    endcase
  end

  // Halfwords need even addresses, words need 4-byte alignment.
  always_comb begin
    misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
               ((funct3[1:0] == 2'b10) && (addr != 2'b00));
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_stage                                                            |
// | Memory-access pipeline stage: passes ALU results through, issues     |
// | aligned loads/stores on a single-outstanding bus, flags faults.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DW = 32
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          ex_valid,
  output logic               ex_ready,
  input  wire logic [DW-1:0] ex_aluOut,
  input  wire logic [DW-1:0] ex_rs2,
  input  wire logic [2:0]    ex_funct3,
  input  wire logic          ex_isLoad,
  input  wire logic          ex_isStore,
  input  wire logic [4:0]    ex_rd,
  input  wire logic          ex_regWrite,
  mem_stage_if.master        dmem,
  output logic               wb_valid,
  output logic [4:0]         wb_rd,
  output logic               wb_regWrite,
  output logic [DW-1:0]      wb_data,
  output logic               wb_fault
);

  state_t      r_state, w_next;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic [4:0]  r_rd;
  logic        r_regwrite;
  logic        r_is_load;

  logic [2:0]  w_f3;
  logic [1:0]  w_lane;
  logic [3:0]  w_wmask;
  logic [31:0] w_wdata;
  logic [31:0] w_load_val;
  logic        w_misalign;
  logic        w_accept;
  logic        w_is_mem;
  logic        w_fault;
  logic        w_go;
  logic        w_done;

  // Ready only in IDLE and never while reset is held.
  assign ex_ready = rst_n && (r_state == ST_IDLE);
  assign w_accept = ex_valid && ex_ready;
  assign w_is_mem = ex_isLoad || ex_isStore;
  assign w_fault  = w_is_mem && (w_misalign || f3_illegal(ex_isLoad, ex_isStore, ex_funct3));
  assign w_go     = w_accept && w_is_mem && !w_fault;
  assign w_done   = (r_state == ST_REQ) && dmem.ack;

  // The aligner sees the incoming op in IDLE and the pending load in REQ.
  assign w_f3   = (r_state == ST_IDLE) ? ex_funct3 : r_funct3;
  assign w_lane = (r_state == ST_IDLE) ? ex_aluOut[1:0] : r_lane;

  mem_align u_align (
    .funct3   (w_f3),
    .addr     (w_lane),
    .rs2      (ex_rs2),
    .rdata    (dmem.rdata),
    .wmask    (w_wmask),
    .wdata    (w_wdata),
    .load_val (w_load_val),
    .misalign (w_misalign)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // FSM next-state: one request outstanding until acknowledged.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_go)     w_next = ST_REQ;
      ST_REQ:  if (dmem.ack) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Request bus and per-access context, held stable while in REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem.req   <= 1'b0;
      dmem.we    <= 1'b0;
      dmem.addr  <= 30'h0;
      dmem.wmask <= 4'h0;
      dmem.wdata <= 32'h0;
      r_funct3   <= 3'h0;
      r_lane     <= 2'h0;
      r_rd       <= 5'h0;
      r_regwrite <= 1'b0;
      r_is_load  <= 1'b0;
    end else if (w_go) begin
      dmem.req   <= 1'b1;
      dmem.we    <= ex_isStore;
      dmem.addr  <= ex_aluOut[31:2];
      dmem.wmask <= ex_isStore ? w_wmask : 4'h0;
      dmem.wdata <= ex_isStore ? w_wdata : 32'h0;
      r_funct3   <= ex_funct3;
      r_lane     <= ex_aluOut[1:0];
      r_rd       <= ex_rd;
      r_regwrite <= ex_regWrite;
      r_is_load  <= ex_isLoad;
    end else if (w_done) begin
      dmem.req   <= 1'b0;
      dmem.we    <= 1'b0;
      dmem.addr  <= 30'h0;
      dmem.wmask <= 4'h0;
      dmem.wdata <= 32'h0;
    end
  end

  // Writeback: single-cycle pulse for pass-through, fault, or completed access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid    <= 1'b0;
      wb_rd       <= 5'h0;
      wb_regWrite <= 1'b0;
      wb_data     <= '0;
      wb_fault    <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      if (w_accept && (!w_is_mem || w_fault)) begin
        wb_valid    <= 1'b1;
        wb_rd       <= ex_rd;
        wb_regWrite <= w_fault ? 1'b0 : ex_regWrite;
        wb_data     <= ex_aluOut;
        wb_fault    <= w_fault;
      end else if (w_done) begin
        wb_valid    <= 1'b1;
        wb_rd       <= r_rd;
        wb_regWrite <= r_is_load && r_regwrite;
        wb_data     <= r_is_load ? w_load_val : '0;
        wb_fault    <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_stage                                                         |
// | Directed self-checking bench with a writeback scoreboard.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mem_stage;

  typedef struct packed {
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] data;
    logic        fault;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_aluOut;
  logic [31:0] ex_rs2;
  logic [2:0]  ex_funct3;
  logic        ex_isLoad;
  logic        ex_isStore;
  logic [4:0]  ex_rd;
  logic        ex_regWrite;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_regWrite;
  logic [31:0] wb_data;
  logic        wb_fault;

  int  n_cmp  = 0;
  int  n_fail = 0;
  wb_t sb_q[$];

  mem_stage_if dif ();

  mem_stage #(.DW(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_aluOut   (ex_aluOut),
    .ex_rs2      (ex_rs2),
    .ex_funct3   (ex_funct3),
    .ex_isLoad   (ex_isLoad),
    .ex_isStore  (ex_isStore),
    .ex_rd       (ex_rd),
    .ex_regWrite (ex_regWrite),
    .dmem        (dif),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_regWrite (wb_regWrite),
    .wb_data     (wb_data),
    .wb_fault    (wb_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample after the edge and score any writeback pulse.
  task automatic tick();
    wb_t e;
    @(posedge clk);
    #1;
    if (wb_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("wb_unexpected", {31'b0, wb_valid}, 32'h0);
      end else begin
        e = sb_q.pop_front();
        chk("wb_rd",       {27'b0, wb_rd},       {27'b0, e.rd});
        chk("wb_regWrite", {31'b0, wb_regWrite}, {31'b0, e.rw});
        chk("wb_data",     wb_data,              e.data);
        chk("wb_fault",    {31'b0, wb_fault},    {31'b0, e.fault});
      end
    end
  endtask

  task automatic set_ex(input logic v, input logic [31:0] alu, input logic [31:0] rs2,
                        input logic [2:0] f3, input logic ld, input logic st,
                        input logic [4:0] rd, input logic rw);
    ex_valid    = v;
    ex_aluOut   = alu;
    ex_rs2      = rs2;
    ex_funct3   = f3;
    ex_isLoad   = ld;
    ex_isStore  = st;
    ex_rd       = rd;
    ex_regWrite = rw;
  endtask

  // One legal access; ack arrives in the (nwait+1)-th REQ cycle.
  task automatic mem_op(input string tag, input logic [31:0] alu, input logic [31:0] rs2,
                        input logic [2:0] f3, input logic st, input logic [4:0] rd,
                        input int nwait, input logic [31:0] rdata,
                        input logic [3:0] exp_mask, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_data);
    set_ex(1'b1, alu, rs2, f3, !st, st, rd, 1'b1);
    sb_q.push_back('{rd: rd, rw: !st, data: exp_data, fault: 1'b0});
    tick();
    set_ex(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i <= nwait; i++) begin
      chk({tag, "_req"},   {31'b0, dif.req},   32'h1);
      chk({tag, "_we"},    {31'b0, dif.we},    {31'b0, st});
      chk({tag, "_addr"},  {2'b0, dif.addr},   {2'b0, alu[31:2]});
      chk({tag, "_wmask"}, {28'b0, dif.wmask}, {28'b0, exp_mask});
      chk({tag, "_wdata"}, dif.wdata,          exp_wdata);
      chk({tag, "_ready"}, {31'b0, ex_ready},  32'h0);
      if (i == nwait) begin
        dif.ack   = 1'b1;
        dif.rdata = rdata;
      end else begin
        dif.rdata = 32'hDEAD_BEEF;
      end
      tick();
    end
    dif.ack   = 1'b0;
    dif.rdata = 32'h0;
    chk({tag, "_wbv"},     {31'b0, wb_valid}, 32'h1);
    chk({tag, "_req_off"}, {31'b0, dif.req},  32'h0);
    chk({tag, "_rdy_on"},  {31'b0, ex_ready}, 32'h1);
  endtask

  initial begin
    set_ex(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 5'd0, 1'b0);
    dif.ack   = 1'b0;
    dif.rdata = 32'h0;
    #3;
    chk("rst_req",   {31'b0, dif.req},  32'h0);
    chk("rst_wbv",   {31'b0, wb_valid}, 32'h0);
    chk("rst_ready", {31'b0, ex_ready}, 32'h0);
    chk("rst_wmask", {28'b0, dif.wmask}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_ready", {31'b0, ex_ready}, 32'h1);

    // Back-to-back pass-through ops.
    for (int i = 1; i <= 3; i++) begin
      set_ex(1'b1, 32'(i * 16), 32'h0, 3'b000, 1'b0, 1'b0, 5'(i), 1'b1);
      sb_q.push_back('{rd: 5'(i), rw: 1'b1, data: 32'(i * 16), fault: 1'b0});
      chk("nm_ready", {31'b0, ex_ready}, 32'h1);
      tick();
      chk("nm_wbv", {31'b0, wb_valid}, 32'h1);
    end
    set_ex(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();

    // Stores.
    mem_op("sb",  32'h0000_1003, 32'h0000_00A5, 3'b000, 1'b1, 5'd4, 2, 32'h0,
           4'b1000, 32'hA5A5_A5A5, 32'h0);
    mem_op("sh",  32'h0000_1002, 32'h1234_BEEF, 3'b001, 1'b1, 5'd5, 0, 32'h0,
           4'b1100, 32'hBEEF_BEEF, 32'h0);
    mem_op("sw",  32'h0000_1000, 32'hCAFE_F00D, 3'b010, 1'b1, 5'd6, 1, 32'h0,
           4'b1111, 32'hCAFE_F00D, 32'h0);

    // Loads with ack in the first request cycle.
    mem_op("lb",  32'h0000_2002, 32'h0, 3'b000, 1'b0, 5'd7, 0, 32'h0080_0000,
           4'b0000, 32'h0, 32'hFFFF_FF80);
    mem_op("lbu", 32'h0000_2002, 32'h0, 3'b100, 1'b0, 5'd8, 0, 32'h0080_0000,
           4'b0000, 32'h0, 32'h0000_0080);
    mem_op("lh",  32'h0000_2002, 32'h0, 3'b001, 1'b0, 5'd9, 0, 32'h8001_FFFF,
           4'b0000, 32'h0, 32'hFFFF_8001);
    mem_op("lhu", 32'h0000_2002, 32'h0, 3'b101, 1'b0, 5'd10, 0, 32'h8001_FFFF,
           4'b0000, 32'h0, 32'h0000_8001);
    mem_op("lw",  32'h0000_2000, 32'h0, 3'b010, 1'b0, 5'd11, 1, 32'h8001_FFFF,
           4'b0000, 32'h0, 32'h8001_FFFF);

    // Faults: misaligned word load, illegal store width, load+store both set.
    set_ex(1'b1, 32'h0000_2001, 32'h0, 3'b010, 1'b1, 1'b0, 5'd12, 1'b1);
    sb_q.push_back('{rd: 5'd12, rw: 1'b0, data: 32'h0000_2001, fault: 1'b1});
    tick();
    chk("flw_wbv", {31'b0, wb_valid}, 32'h1);
    chk("flw_req", {31'b0, dif.req},  32'h0);
    set_ex(1'b1, 32'h0000_3000, 32'h0, 3'b011, 1'b0, 1'b1, 5'd13, 1'b0);
    sb_q.push_back('{rd: 5'd13, rw: 1'b0, data: 32'h0000_3000, fault: 1'b1});
    tick();
    chk("fsd_req", {31'b0, dif.req}, 32'h0);
    set_ex(1'b1, 32'h0000_3004, 32'h0, 3'b010, 1'b1, 1'b1, 5'd14, 1'b1);
    sb_q.push_back('{rd: 5'd14, rw: 1'b0, data: 32'h0000_3004, fault: 1'b1});
    tick();
    chk("fls_req",   {31'b0, dif.req},  32'h0);
    chk("fls_ready", {31'b0, ex_ready}, 32'h1);
    set_ex(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();

    // Reset while a request is pending.
    set_ex(1'b1, 32'h0000_2000, 32'h0, 3'b010, 1'b1, 1'b0, 5'd15, 1'b1);
    tick();
    set_ex(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("rr_req_on", {31'b0, dif.req}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rr_req_off", {31'b0, dif.req},  32'h0);
    chk("rr_ready",   {31'b0, ex_ready}, 32'h0);
    chk("rr_wbv",     {31'b0, wb_valid}, 32'h0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("rr_ready_on", {31'b0, ex_ready}, 32'h1);
    chk("rr_wbv_off",  {31'b0, wb_valid}, 32'h0);

    // Spurious acknowledge while idle.
    dif.ack   = 1'b1;
    dif.rdata = 32'h1234_5678;
    tick();
    chk("sp_wbv1", {31'b0, wb_valid}, 32'h0);
    tick();
    chk("sp_wbv2", {31'b0, wb_valid}, 32'h0);
    dif.ack = 1'b0;
    tick();
    chk("sp_req", {31'b0, dif.req}, 32'h0);

    chk("sb_left", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
